// File: rtl/sat_bin_loader_if.sv
// rtl/sat_bin_loader_if.sv - clause and variable word streams into the loader
interface sat_bin_loader_if #(
    parameter int WIDTH_CLAUSES = 16,
    parameter int WIDTH_VAR     = 12
);
    logic                     c_valid_i;
    logic [WIDTH_CLAUSES-1:0] c_data_i;
    logic                     c_ready_o;
    logic                     v_valid_i;
    logic [WIDTH_VAR-1:0]     v_data_i;
    logic                     v_ready_o;

    // word source side
    modport master (
        output c_valid_i, c_data_i, v_valid_i, v_data_i,
        input  c_ready_o, v_ready_o
    );

    // loader side
    modport slave (
        input  c_valid_i, c_data_i, v_valid_i, v_data_i,
        output c_ready_o, v_ready_o
    );
endinterface

// File: rtl/sat_bin_loader.sv
// rtl/sat_bin_loader.sv - load-and-launch controller for sat_bin
module sat_bin_loader #(
    parameter int WIDTH_CLAUSES      = 16,
    parameter int WIDTH_VAR          = 12,
    parameter int WIDTH_VAR_STATES   = 19,
    parameter int WIDTH_LVL_STATES   = 11,
    parameter int WIDTH_BIN_SIZE     = 8,
    parameter int ADDR_WIDTH_CLAUSES = 9,
    parameter int ADDR_WIDTH_VAR     = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start_i,
    input  logic                          abort_i,
    input  logic [WIDTH_CLAUSES-1:0]      nb_i,
    input  logic [WIDTH_VAR-1:0]          nv_i,
    input  logic [WIDTH_BIN_SIZE-1:0]     cmax_i,
    input  logic [WIDTH_BIN_SIZE-1:0]     vmax_i,
    sat_bin_loader_if.slave               strm,
    output logic                          apply_ex_o,
    output logic                          ram_we_c_ex_o,
    output logic [WIDTH_CLAUSES-1:0]      ram_din_c_ex_o,
    output logic [ADDR_WIDTH_CLAUSES-1:0] ram_addr_c_ex_o,
    output logic                          ram_we_v_ex_o,
    output logic [WIDTH_VAR-1:0]          ram_din_v_ex_o,
    output logic [ADDR_WIDTH_VAR-1:0]     ram_addr_v_ex_o,
    output logic                          ram_we_vs_ex_o,
    output logic [WIDTH_VAR_STATES-1:0]   ram_din_vs_ex_o,
    output logic [ADDR_WIDTH_VAR-1:0]     ram_addr_vs_ex_o,
    output logic                          ram_we_ls_ex_o,
    output logic [WIDTH_LVL_STATES-1:0]   ram_din_ls_ex_o,
    output logic [ADDR_WIDTH_VAR-1:0]     ram_addr_ls_ex_o,
    output logic                          start_o,
    output logic                          bin_info_en_o,
    output logic [WIDTH_CLAUSES-1:0]      nb_all_o,
    output logic [WIDTH_VAR-1:0]          nv_all_o,
    input  logic                          done_i,
    input  logic                          global_sat_i,
    input  logic                          global_unsat_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          sat_o,
    output logic                          unsat_o,
    output logic                          cfg_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_START,
        S_RUN
    } state_t;

    localparam int PW = WIDTH_CLAUSES + WIDTH_BIN_SIZE;
    localparam logic [PW-1:0] NC_MAX = PW'((1 << ADDR_WIDTH_CLAUSES) - 1);
    localparam logic [PW-1:0] NV_MAX = PW'((1 << ADDR_WIDTH_VAR) - 1);

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH_CLAUSES-1:0]   nc_q, nc_d;
    logic [ADDR_WIDTH_VAR-1:0]       nvt_q, nvt_d;
    logic [ADDR_WIDTH_CLAUSES-1:0]   c_cnt_q, c_cnt_d;
    logic [ADDR_WIDTH_VAR-1:0]       v_cnt_q, v_cnt_d;
    logic [WIDTH_CLAUSES-1:0]        nb_all_q, nb_all_d;
    logic [WIDTH_VAR-1:0]            nv_all_q, nv_all_d;
    logic                            c_ready_q, c_ready_d;
    logic                            v_ready_q, v_ready_d;
    logic                            apply_q, apply_d;
    logic                            we_c_q, we_c_d;
    logic [WIDTH_CLAUSES-1:0]        din_c_q, din_c_d;
    logic [ADDR_WIDTH_CLAUSES-1:0]   addr_c_q, addr_c_d;
    logic                            we_v_q, we_v_d;
    logic [WIDTH_VAR-1:0]            din_v_q, din_v_d;
    logic [ADDR_WIDTH_VAR-1:0]       addr_v_q, addr_v_d;
    logic                            start_q, start_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            sat_q, sat_d;
    logic                            unsat_q, unsat_d;
    logic                            cfg_err_q, cfg_err_d;

    logic [PW-1:0] nc_full;
    logic [PW-1:0] nv_full;
    logic          cfg_bad;
    logic          c_fire;
    logic          v_fire;

    // Geometry products at full width so an oversize request cannot wrap into range
    assign nc_full = PW'(nb_i) * PW'(cmax_i);
    assign nv_full = PW'(nb_i) * PW'(vmax_i);
    assign cfg_bad = (nb_i == '0) || (nc_full > NC_MAX) || (nv_full > NV_MAX);

    // A beat is taken only when the registered ready was offered during LOAD
    assign c_fire = (state_q == S_LOAD) && c_ready_q && strm.c_valid_i;
    assign v_fire = (state_q == S_LOAD) && v_ready_q && strm.v_valid_i;

    // Next-state, counters, write pipeline and status; outputs decode from the next state
    always_comb begin
        state_d   = state_q;
        nc_d      = nc_q;
        nvt_d     = nvt_q;
        c_cnt_d   = c_cnt_q;
        v_cnt_d   = v_cnt_q;
        nb_all_d  = nb_all_q;
        nv_all_d  = nv_all_q;
        we_c_d    = 1'b0;
        din_c_d   = din_c_q;
        addr_c_d  = addr_c_q;
        we_v_d    = 1'b0;
        din_v_d   = din_v_q;
        addr_v_d  = addr_v_q;
        done_d    = 1'b0;
        sat_d     = sat_q;
        unsat_d   = unsat_q;
        cfg_err_d = 1'b0;

        if (abort_i) begin
            state_d = S_IDLE;
            c_cnt_d = '0;
            v_cnt_d = '0;
            sat_d   = 1'b0;
            unsat_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_start_i) begin
                        if (cfg_bad) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            nb_all_d = nb_i;
                            nv_all_d = nv_i;
                            nc_d     = nc_full[ADDR_WIDTH_CLAUSES-1:0];
                            nvt_d    = nv_full[ADDR_WIDTH_VAR-1:0];
                            c_cnt_d  = '0;
                            v_cnt_d  = '0;
                            sat_d    = 1'b0;
                            unsat_d  = 1'b0;
                            state_d  = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (c_fire) begin
                        we_c_d   = 1'b1;
                        din_c_d  = strm.c_data_i;
                        addr_c_d = c_cnt_q + 1'b1;
                        c_cnt_d  = c_cnt_q + 1'b1;
                    end
                    if (v_fire) begin
                        we_v_d   = 1'b1;
                        din_v_d  = strm.v_data_i;
                        addr_v_d = v_cnt_q + 1'b1;
                        v_cnt_d  = v_cnt_q + 1'b1;
                    end
                    // Post-increment counts: the final writes land in the FLUSH cycle
                    if ((c_cnt_d == nc_q) && (v_cnt_d == nvt_q)) begin
                        state_d = S_FLUSH;
                    end
                end
                S_FLUSH: state_d = S_START;
                S_START: state_d = S_RUN;
                S_RUN: begin
                    if (done_i) begin
                        sat_d   = global_sat_i;
                        unsat_d = global_unsat_i;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        c_ready_d = (state_d == S_LOAD) && (c_cnt_d < nc_d);
        v_ready_d = (state_d == S_LOAD) && (v_cnt_d < nvt_d);
        apply_d   = (state_d == S_LOAD) || (state_d == S_FLUSH);
        start_d   = (state_d == S_START);
        busy_d    = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            nc_q      <= '0;
            nvt_q     <= '0;
            c_cnt_q   <= '0;
            v_cnt_q   <= '0;
            nb_all_q  <= '0;
            nv_all_q  <= '0;
            c_ready_q <= 1'b0;
            v_ready_q <= 1'b0;
            apply_q   <= 1'b0;
            we_c_q    <= 1'b0;
            din_c_q   <= '0;
            addr_c_q  <= '0;
            we_v_q    <= 1'b0;
            din_v_q   <= '0;
            addr_v_q  <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
            unsat_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nc_q      <= nc_d;
            nvt_q     <= nvt_d;
            c_cnt_q   <= c_cnt_d;
            v_cnt_q   <= v_cnt_d;
            nb_all_q  <= nb_all_d;
            nv_all_q  <= nv_all_d;
            c_ready_q <= c_ready_d;
            v_ready_q <= v_ready_d;
            apply_q   <= apply_d;
            we_c_q    <= we_c_d;
            din_c_q   <= din_c_d;
            addr_c_q  <= addr_c_d;
            we_v_q    <= we_v_d;
            din_v_q   <= din_v_d;
            addr_v_q  <= addr_v_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sat_q     <= sat_d;
            unsat_q   <= unsat_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign strm.c_ready_o   = c_ready_q;
    assign strm.v_ready_o   = v_ready_q;
    assign apply_ex_o       = apply_q;
    assign ram_we_c_ex_o    = we_c_q;
    assign ram_din_c_ex_o   = din_c_q;
    assign ram_addr_c_ex_o  = addr_c_q;
    assign ram_we_v_ex_o    = we_v_q;
    assign ram_din_v_ex_o   = din_v_q;
    assign ram_addr_v_ex_o  = addr_v_q;
    // var-state and lvl-state RAMs are zero-filled alongside each variable word
    assign ram_we_vs_ex_o   = we_v_q;
    assign ram_din_vs_ex_o  = '0;
    assign ram_addr_vs_ex_o = addr_v_q;
    assign ram_we_ls_ex_o   = we_v_q;
    assign ram_din_ls_ex_o  = '0;
    assign ram_addr_ls_ex_o = addr_v_q;
    assign start_o          = start_q;
    assign bin_info_en_o    = start_q;
    assign nb_all_o         = nb_all_q;
    assign nv_all_o         = nv_all_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign sat_o            = sat_q;
    assign unsat_o          = unsat_q;
    assign cfg_err_o        = cfg_err_q;

endmodule

// File: tb/tb_sat_bin_loader.sv
// tb/tb_sat_bin_loader.sv - randomized self-checking bench for sat_bin_loader
module tb_sat_bin_loader;
    localparam int WC = 16, WV = 12, WVS = 19, WLS = 11, WB = 8, AC = 9, AV = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic           load_start_i, abort_i;
    logic [WC-1:0]  nb_i;
    logic [WV-1:0]  nv_i;
    logic [WB-1:0]  cmax_i, vmax_i;
    logic           apply_ex_o;
    logic           ram_we_c_ex_o, ram_we_v_ex_o, ram_we_vs_ex_o, ram_we_ls_ex_o;
    logic [WC-1:0]  ram_din_c_ex_o;
    logic [AC-1:0]  ram_addr_c_ex_o;
    logic [WV-1:0]  ram_din_v_ex_o;
    logic [AV-1:0]  ram_addr_v_ex_o, ram_addr_vs_ex_o, ram_addr_ls_ex_o;
    logic [WVS-1:0] ram_din_vs_ex_o;
    logic [WLS-1:0] ram_din_ls_ex_o;
    logic           start_o, bin_info_en_o;
    logic [WC-1:0]  nb_all_o;
    logic [WV-1:0]  nv_all_o;
    logic           done_i, global_sat_i, global_unsat_i;
    logic           busy_o, done_o, sat_o, unsat_o, cfg_err_o;

    sat_bin_loader_if #(.WIDTH_CLAUSES(WC), .WIDTH_VAR(WV)) strm ();

    sat_bin_loader dut (
        .clk(clk), .rst(rst),
        .load_start_i(load_start_i), .abort_i(abort_i),
        .nb_i(nb_i), .nv_i(nv_i), .cmax_i(cmax_i), .vmax_i(vmax_i),
        .strm(strm.slave),
        .apply_ex_o(apply_ex_o),
        .ram_we_c_ex_o(ram_we_c_ex_o), .ram_din_c_ex_o(ram_din_c_ex_o), .ram_addr_c_ex_o(ram_addr_c_ex_o),
        .ram_we_v_ex_o(ram_we_v_ex_o), .ram_din_v_ex_o(ram_din_v_ex_o), .ram_addr_v_ex_o(ram_addr_v_ex_o),
        .ram_we_vs_ex_o(ram_we_vs_ex_o), .ram_din_vs_ex_o(ram_din_vs_ex_o), .ram_addr_vs_ex_o(ram_addr_vs_ex_o),
        .ram_we_ls_ex_o(ram_we_ls_ex_o), .ram_din_ls_ex_o(ram_din_ls_ex_o), .ram_addr_ls_ex_o(ram_addr_ls_ex_o),
        .start_o(start_o), .bin_info_en_o(bin_info_en_o),
        .nb_all_o(nb_all_o), .nv_all_o(nv_all_o),
        .done_i(done_i), .global_sat_i(global_sat_i), .global_unsat_i(global_unsat_i),
        .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o), .unsat_o(unsat_o), .cfg_err_o(cfg_err_o)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: the k-th accepted word of each stream lands at address k
    logic [WC-1:0] exp_c[$];
    logic [WV-1:0] exp_v[$];
    int c_wr = 0;
    int v_wr = 0;
    int last_nb = 0;
    int last_nv = 0;

    always @(negedge clk) begin
        if (rst && ram_we_c_ex_o) begin
            c_wr++;
            chk("c_addr", ram_addr_c_ex_o, c_wr);
            chk("c_apply", apply_ex_o, 1);
            if (exp_c.size() == 0) chk("c_extra_write", 1, 0);
            else chk("c_data", ram_din_c_ex_o, exp_c.pop_front());
        end
        if (rst && ram_we_v_ex_o) begin
            v_wr++;
            chk("v_addr", ram_addr_v_ex_o, v_wr);
            chk("vs_we", ram_we_vs_ex_o, 1);
            chk("ls_we", ram_we_ls_ex_o, 1);
            chk("vs_addr", ram_addr_vs_ex_o, v_wr);
            chk("ls_addr", ram_addr_ls_ex_o, v_wr);
            chk("vs_din", ram_din_vs_ex_o, 0);
            chk("ls_din", ram_din_ls_ex_o, 0);
            if (exp_v.size() == 0) chk("v_extra_write", 1, 0);
            else chk("v_data", ram_din_v_ex_o, exp_v.pop_front());
        end
        if (rst && !ram_we_v_ex_o && (ram_we_vs_ex_o || ram_we_ls_ex_o)) chk("state_we_alone", 1, 0);
    end

    // All tasks start and end one time unit after a rising edge
    task automatic pulse_load(input int b, input int v, input int cm, input int vm);
        nb_i = WC'(b); nv_i = WV'(v); cmax_i = WB'(cm); vmax_i = WB'(vm);
        c_wr = 0; v_wr = 0;
        exp_c.delete(); exp_v.delete();
        load_start_i = 1'b1;
        @(posedge clk); #1;
        load_start_i = 1'b0;
    endtask

    task automatic run_load(input int b, input int v, input int cm, input int vm,
                            input int c_pct, input int v_pct, input bit early_done, input bit poke_run);
        int nc, nvv, cs, vs, cyc, r;
        nc = b * cm; nvv = b * vm; cs = 0; vs = 0; cyc = 0;
        pulse_load(b, v, cm, vm);
        last_nb = b; last_nv = v;
        chk("busy_load", busy_o, 1);
        while ((cs < nc || vs < nvv) && cyc < 3000) begin
            strm.c_valid_i = (cs < nc) && ($urandom_range(1, 100) <= c_pct);
            strm.c_data_i  = WC'($urandom);
            strm.v_valid_i = (vs < nvv) && ($urandom_range(1, 100) <= v_pct);
            strm.v_data_i  = WV'($urandom);
            @(negedge clk);
            chk("c_ready", strm.c_ready_o, cs < nc);
            chk("v_ready", strm.v_ready_o, vs < nvv);
            if (strm.c_valid_i && strm.c_ready_o) begin exp_c.push_back(strm.c_data_i); cs++; end
            if (strm.v_valid_i && strm.v_ready_o) begin exp_v.push_back(strm.v_data_i); vs++; end
            @(posedge clk); #1;
            cyc++;
        end
        strm.c_valid_i = 1'b0;
        strm.v_valid_i = 1'b0;
        chk("load_bounded", cyc < 3000, 1);
        if (nc + nvv > 0) chk("apply_flush", apply_ex_o, 1);
        cyc = 0;
        while (!start_o && cyc < 6) begin @(posedge clk); #1; cyc++; end
        chk("start_latency", cyc, (nc + nvv > 0) ? 1 : 2);
        chk("start_seen", start_o, 1);
        chk("bin_info_en", bin_info_en_o, 1);
        chk("apply_start", apply_ex_o, 0);
        chk("nb_all", nb_all_o, b);
        chk("nv_all", nv_all_o, v);
        if (early_done) begin done_i = 1'b1; global_sat_i = 1'b1; end
        @(posedge clk); #1;
        done_i = 1'b0; global_sat_i = 1'b0;
        chk("start_one_cycle", start_o, 0);
        chk("busy_run", busy_o, 1);
        if (early_done) chk("early_done_ignored", done_o, 0);
        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
        if (poke_run) begin
            nb_i = WC'(b + 3);
            load_start_i = 1'b1;
            @(posedge clk); #1;
            load_start_i = 1'b0;
            chk("ls_in_run_busy", busy_o, 1);
            chk("ls_in_run_nb", nb_all_o, b);
        end
        r = $urandom_range(0, 1);
        done_i = 1'b1; global_sat_i = r[0]; global_unsat_i = ~r[0];
        @(posedge clk); #1;
        done_i = 1'b0; global_sat_i = 1'b0; global_unsat_i = 1'b0;
        chk("done_pulse", done_o, 1);
        chk("sat", sat_o, r);
        chk("unsat", unsat_o, 1 - r);
        chk("idle_after_done", busy_o, 0);
        @(posedge clk); #1;
        chk("done_one_cycle", done_o, 0);
        chk("sat_hold", sat_o, r);
        chk("c_write_count", c_wr, nc);
        chk("v_write_count", v_wr, nvv);
        chk("c_queue_empty", exp_c.size(), 0);
        chk("v_queue_empty", exp_v.size(), 0);
    endtask

    task automatic cfg_reject(input int b, input int cm, input int vm);
        pulse_load(b, 7, cm, vm);
        chk("cfg_err_pulse", cfg_err_o, 1);
        chk("cfg_err_busy", busy_o, 0);
        chk("cfg_err_apply", apply_ex_o, 0);
        chk("cfg_err_ready", strm.c_ready_o | strm.v_ready_o, 0);
        @(posedge clk); #1;
        chk("cfg_err_one_cycle", cfg_err_o, 0);
        chk("cfg_err_nb_kept", nb_all_o, last_nb);
    endtask

    initial begin
        int cs, cyc;
        load_start_i = 0; abort_i = 0; nb_i = 0; nv_i = 0; cmax_i = 0; vmax_i = 0;
        done_i = 0; global_sat_i = 0; global_unsat_i = 0;
        strm.c_valid_i = 0; strm.c_data_i = 0; strm.v_valid_i = 0; strm.v_data_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_outputs", {apply_ex_o, start_o, bin_info_en_o, done_o, sat_o, unsat_o, cfg_err_o,
                            ram_we_c_ex_o, ram_we_v_ex_o, strm.c_ready_o, strm.v_ready_o}, 0);
        chk("rst_nb_all", nb_all_o, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        run_load(2, 10, 8, 8, 100, 100, 1'b0, 1'b0);
        run_load(2, 10, 8, 8, 50, 100, 1'b1, 1'b1);
        run_load(2, 10, 8, 8, 100, 40, 1'b0, 1'b1);
        run_load(1, 3, 0, 0, 100, 100, 1'b0, 1'b0);
        run_load(7, 100, 73, 1, 100, 100, 1'b0, 1'b0);

        cfg_reject(64, 8, 1);
        cfg_reject(0, 4, 4);
        cfg_reject(3, 1, 171);
        cfg_reject(3, 171, 1);

        for (int i = 0; i < 6; i++) begin
            run_load($urandom_range(1, 4), $urandom_range(0, 4095), $urandom_range(0, 20),
                     $urandom_range(0, 20), $urandom_range(30, 100), $urandom_range(30, 100),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        chk("abort_clears_result", {sat_o, unsat_o}, 0);

        pulse_load(2, 10, 8, 8);
        cs = 0; cyc = 0;
        while (cs < 5 && cyc < 50) begin
            strm.c_valid_i = 1'b1;
            strm.c_data_i  = WC'($urandom);
            @(negedge clk);
            if (strm.c_ready_o) begin exp_c.push_back(strm.c_data_i); cs++; end
            @(posedge clk); #1;
            cyc++;
        end
        strm.c_valid_i = 1'b0;
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_outputs", {apply_ex_o, ram_we_c_ex_o, ram_we_v_ex_o, ram_we_vs_ex_o, ram_we_ls_ex_o,
                              start_o, done_o, strm.c_ready_o, strm.v_ready_o}, 0);
        chk("abort_writes", c_wr, 5);
        @(posedge clk); #1;
        run_load(1, 9, 6, 5, 100, 100, 1'b0, 1'b0);

        pulse_load(1, 4, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_run", busy_o, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_run_busy", busy_o, 0);
        chk("rst_run_outputs", {apply_ex_o, start_o, bin_info_en_o, done_o, sat_o, unsat_o, cfg_err_o,
                                ram_we_c_ex_o, ram_we_v_ex_o, strm.c_ready_o, strm.v_ready_o}, 0);
        chk("rst_run_latched", {nb_all_o, nv_all_o}, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run_load(3, 20, 5, 4, 70, 70, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
